// File: rtl/prio_scan_encoder_if.sv
// -----------------------------------------------------------------------------
// prio_scan_encoder_if
//   Handshake bundle for prio_scan_encoder: request-vector capture side
//   (in_valid/in_ready/in_vec) and index-stream side
//   (out_valid/out_ready/out_idx/out_last/out_none[/out_count]).
//
//   Parameters:
//     N     request vector width (N >= 2)
//
//   Signals:
//     in_valid   request vector offered            (master -> slave)
//     in_ready   encoder idle, can capture         (slave  -> master)
//     in_vec     N-bit request vector              (master -> slave)
//     out_valid  out_idx/out_last/out_none valid   (slave  -> master)
//     out_ready  consumer accepts beat             (master -> slave)
//     out_idx    index of current pending bit      (slave  -> master)
//     out_last   final beat for this vector        (slave  -> master)
//     out_none   captured vector was all-zero      (slave  -> master)
//     out_count  popcount of captured vector       (slave  -> master)
//
//   Modports:
//     slave   the encoder
//     master  request source plus index consumer
//
//   Optional feature macro: PRIO_SCAN_COUNT_EN adds out_count.
// -----------------------------------------------------------------------------
interface prio_scan_encoder_if #(
   parameter int unsigned N = 16
);
   localparam int unsigned IDXW = $clog2(N);

   logic            in_valid;
   logic            in_ready;
   logic [N-1:0]    in_vec;
   logic            out_valid;
   logic            out_ready;
   logic [IDXW-1:0] out_idx;
   logic            out_last;
   logic            out_none;
`ifdef PRIO_SCAN_COUNT_EN
   logic [IDXW:0]   out_count;
`endif

   modport slave (
      input  in_valid, in_vec, out_ready,
`ifdef PRIO_SCAN_COUNT_EN
      output out_count,
`endif
      output in_ready, out_valid, out_idx, out_last, out_none
   );

   modport master (
      output in_valid, in_vec, out_ready,
`ifdef PRIO_SCAN_COUNT_EN
      input  out_count,
`endif
      input  in_ready, out_valid, out_idx, out_last, out_none
   );
endinterface

// File: rtl/prio_scan_encoder.sv
// -----------------------------------------------------------------------------
// prio_scan_encoder
//   Sequential priority encoder. Captures an N-bit request vector while idle,
//   then emits the index of every set bit, one per out_valid/out_ready beat,
//   in priority order. An all-zero vector produces a single beat flagged
//   with out_none. No new vector is accepted until the current one is fully
//   drained.
//
//   Parameters:
//     N          request vector width, N >= 2
//     MSB_FIRST  1: highest set index first, 0: lowest set index first
//
//   Ports:
//     clk        clock, rising edge
//     rst_n      asynchronous reset, active low
//     bus        prio_scan_encoder_if.slave (see interface for signal list)
//
//   Optional feature macro: PRIO_SCAN_COUNT_EN
//     defined   -> out_count carries popcount of the captured vector
//     undefined -> out_count and the popcount logic are absent
// -----------------------------------------------------------------------------
module prio_scan_encoder #(
   parameter int unsigned N         = 16,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   prio_scan_encoder_if.slave bus
);

   localparam int unsigned IDXW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      EMPTY = 2'd2
   } state_t;

   state_t          state;
   logic [N-1:0]    pending;

   logic            in_ready_q;
   logic            valid_q;
   logic [IDXW-1:0] idx_q;
   logic            last_q;
   logic            none_q;

   logic [N-1:0]    clr_mask;
   logic [N-1:0]    scan_src;
   logic [IDXW-1:0] nxt_idx;
   logic            nxt_single;

`ifdef PRIO_SCAN_COUNT_EN
   logic [IDXW:0]   count_q;
   logic [IDXW:0]   in_pop;
`endif

   // The output registers are loaded with the priority decode of the vector
   // that will be pending after this edge: the incoming vector when idle,
   // otherwise pending with the accepted bit removed. This keeps every output
   // a plain flop while still showing the next index in the very next cycle.
   always_comb begin
      clr_mask         = '0;
      clr_mask[idx_q]  = 1'b1;
      if (state == IDLE) begin
         scan_src = bus.in_vec;
      end else begin
         scan_src = pending & ~clr_mask;
      end
   end

   // Last-match-wins loop: ascending order yields the highest set index,
   // descending order yields the lowest.
   always_comb begin
      nxt_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (MSB_FIRST != 0) begin
            if (scan_src[i]) begin
               nxt_idx = IDXW'(i);
            end
         end else begin
            if (scan_src[N-1-i]) begin
               nxt_idx = IDXW'(N-1-i);
            end
         end
      end
   end

   always_comb begin
      nxt_single = (scan_src != '0) && ((scan_src & (scan_src - N'(1))) == '0);
   end

`ifdef PRIO_SCAN_COUNT_EN
   always_comb begin
      in_pop = '0;
      for (int unsigned i = 0; i < N; i++) begin
         in_pop = in_pop + (IDXW+1)'(bus.in_vec[i]);
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pending    <= '0;
         in_ready_q <= 1'b1;
         valid_q    <= 1'b0;
         idx_q      <= '0;
         last_q     <= 1'b0;
         none_q     <= 1'b0;
`ifdef PRIO_SCAN_COUNT_EN
         count_q    <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  pending    <= bus.in_vec;
                  in_ready_q <= 1'b0;
                  valid_q    <= 1'b1;
`ifdef PRIO_SCAN_COUNT_EN
                  count_q    <= in_pop;
`endif
                  if (bus.in_vec != '0) begin
                     state  <= SCAN;
                     idx_q  <= nxt_idx;
                     last_q <= nxt_single;
                     none_q <= 1'b0;
                  end else begin
                     state  <= EMPTY;
                     idx_q  <= '0;
                     last_q <= 1'b1;
                     none_q <= 1'b1;
                  end
               end
            end

            SCAN: begin
               if (bus.out_ready) begin
                  pending <= scan_src;
                  if (last_q) begin
                     state      <= IDLE;
                     in_ready_q <= 1'b1;
                     valid_q    <= 1'b0;
                     idx_q      <= '0;
                     last_q     <= 1'b0;
`ifdef PRIO_SCAN_COUNT_EN
                     count_q    <= '0;
`endif
                  end else begin
                     idx_q  <= nxt_idx;
                     last_q <= nxt_single;
                  end
               end
            end

            EMPTY: begin
               if (bus.out_ready) begin
                  state      <= IDLE;
                  pending    <= '0;
                  in_ready_q <= 1'b1;
                  valid_q    <= 1'b0;
                  idx_q      <= '0;
                  last_q     <= 1'b0;
                  none_q     <= 1'b0;
               end
            end

            default: begin
               state      <= IDLE;
               pending    <= '0;
               in_ready_q <= 1'b1;
               valid_q    <= 1'b0;
               idx_q      <= '0;
               last_q     <= 1'b0;
               none_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = valid_q;
   assign bus.out_idx   = idx_q;
   assign bus.out_last  = last_q;
   assign bus.out_none  = none_q;
`ifdef PRIO_SCAN_COUNT_EN
   assign bus.out_count = count_q;
`endif

endmodule

// File: tb/tb_prio_scan_encoder.sv
// -----------------------------------------------------------------------------
// tb_prio_scan_encoder
//   Directed self-checking bench for prio_scan_encoder with N=16. Two
//   instances share clock and reset: dut_m (MSB_FIRST=1) and dut_l
//   (MSB_FIRST=0). Inputs change and outputs are sampled 1 time unit after
//   the rising edge.
// -----------------------------------------------------------------------------
module tb_prio_scan_encoder;

   logic clk;
   logic rst_n;

   int n_checks;
   int n_fail;

   prio_scan_encoder_if #(.N(16)) m_if ();
   prio_scan_encoder_if #(.N(16)) l_if ();

   prio_scan_encoder #(.N(16), .MSB_FIRST(1)) dut_m (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (m_if.slave)
   );

   prio_scan_encoder #(.N(16), .MSB_FIRST(0)) dut_l (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (l_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst_n          = 1'b0;
      m_if.in_valid  = 1'b0;
      m_if.in_vec    = '0;
      m_if.out_ready = 1'b0;
      l_if.in_valid  = 1'b0;
      l_if.in_vec    = '0;
      l_if.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (m_if.in_ready !== 1'b1 || l_if.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b/%b expected 1/1", m_if.in_ready, l_if.in_ready);
      end
      n_checks++;
      if (m_if.out_valid !== 1'b0 || l_if.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out_valid: got %b/%b expected 0/0", m_if.out_valid, l_if.out_valid);
      end
      n_checks++;
      if (m_if.out_idx !== 4'd0 || m_if.out_last !== 1'b0 || m_if.out_none !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got idx=%0d last=%b none=%b expected idx=0 last=0 none=0",
                  m_if.out_idx, m_if.out_last, m_if.out_none);
      end
`ifdef PRIO_SCAN_COUNT_EN
      n_checks++;
      if (m_if.out_count !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d expected 0", m_if.out_count);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (m_if.in_ready !== 1'b1 || m_if.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got in_ready=%b out_valid=%b expected 1/0",
                  m_if.in_ready, m_if.out_valid);
      end
   endtask

   task automatic test_msb_first();
      int exp_idx [4] = '{15, 10, 5, 0};
      m_if.in_vec    = 16'h8421;
      m_if.in_valid  = 1'b1;
      m_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      m_if.in_valid = 1'b0;
      m_if.in_vec   = '0;
      for (int b = 0; b < 4; b++) begin
         n_checks++;
         if (m_if.out_valid !== 1'b1 || m_if.in_ready !== 1'b0 ||
             m_if.out_idx !== 4'(exp_idx[b]) || m_if.out_last !== (b == 3)) begin
            n_fail++;
            $display("FAIL msb_beat%0d: got valid=%b ready=%b idx=%0d last=%b expected 1 0 %0d %b",
                     b, m_if.out_valid, m_if.in_ready, m_if.out_idx, m_if.out_last,
                     exp_idx[b], (b == 3));
         end
`ifdef PRIO_SCAN_COUNT_EN
         n_checks++;
         if (m_if.out_count !== 5'd4) begin
            n_fail++;
            $display("FAIL msb_count%0d: got %0d expected 4", b, m_if.out_count);
         end
`endif
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (m_if.in_ready !== 1'b1 || m_if.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL msb_done: got in_ready=%b out_valid=%b expected 1/0",
                  m_if.in_ready, m_if.out_valid);
      end
   endtask

   task automatic test_lsb_first();
      int exp_idx [4] = '{0, 5, 10, 15};
      l_if.in_vec    = 16'h8421;
      l_if.in_valid  = 1'b1;
      l_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      l_if.in_valid = 1'b0;
      l_if.in_vec   = '0;
      for (int b = 0; b < 4; b++) begin
         n_checks++;
         if (l_if.out_valid !== 1'b1 || l_if.out_idx !== 4'(exp_idx[b]) ||
             l_if.out_last !== (b == 3)) begin
            n_fail++;
            $display("FAIL lsb_beat%0d: got valid=%b idx=%0d last=%b expected 1 %0d %b",
                     b, l_if.out_valid, l_if.out_idx, l_if.out_last, exp_idx[b], (b == 3));
         end
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (l_if.in_ready !== 1'b1 || l_if.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL lsb_done: got in_ready=%b out_valid=%b expected 1/0",
                  l_if.in_ready, l_if.out_valid);
      end
   endtask

   task automatic test_empty();
      m_if.in_vec    = 16'h0000;
      m_if.in_valid  = 1'b1;
      m_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      m_if.in_valid = 1'b0;
      n_checks++;
      if (m_if.out_valid !== 1'b1 || m_if.out_none !== 1'b1 || m_if.out_last !== 1'b1 ||
          m_if.out_idx !== 4'd0 || m_if.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_beat: got valid=%b none=%b last=%b idx=%0d ready=%b expected 1 1 1 0 0",
                  m_if.out_valid, m_if.out_none, m_if.out_last, m_if.out_idx, m_if.in_ready);
      end
`ifdef PRIO_SCAN_COUNT_EN
      n_checks++;
      if (m_if.out_count !== 5'd0) begin
         n_fail++;
         $display("FAIL empty_count: got %0d expected 0", m_if.out_count);
      end
`endif
      @(posedge clk);
      #1;
      n_checks++;
      if (m_if.in_ready !== 1'b1 || m_if.out_valid !== 1'b0 || m_if.out_none !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_done: got in_ready=%b out_valid=%b none=%b expected 1 0 0",
                  m_if.in_ready, m_if.out_valid, m_if.out_none);
      end
   endtask

   task automatic test_stall();
      m_if.in_vec    = 16'h0300;
      m_if.in_valid  = 1'b1;
      m_if.out_ready = 1'b0;
      @(posedge clk);
      #1;
      // Keep offering a different vector: it must be ignored outside IDLE.
      m_if.in_vec = 16'hFFFF;
      for (int c = 0; c < 4; c++) begin
         n_checks++;
         if (m_if.out_valid !== 1'b1 || m_if.out_idx !== 4'd9 || m_if.out_last !== 1'b0 ||
             m_if.out_none !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold%0d: got valid=%b idx=%0d last=%b none=%b expected 1 9 0 0",
                     c, m_if.out_valid, m_if.out_idx, m_if.out_last, m_if.out_none);
         end
`ifdef PRIO_SCAN_COUNT_EN
         n_checks++;
         if (m_if.out_count !== 5'd2) begin
            n_fail++;
            $display("FAIL stall_count%0d: got %0d expected 2", c, m_if.out_count);
         end
`endif
         if (c < 3) begin
            @(posedge clk);
            #1;
         end
      end
      m_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (m_if.out_valid !== 1'b1 || m_if.out_idx !== 4'd8 || m_if.out_last !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_beat8: got valid=%b idx=%0d last=%b expected 1 8 1",
                  m_if.out_valid, m_if.out_idx, m_if.out_last);
      end
`ifdef PRIO_SCAN_COUNT_EN
      n_checks++;
      if (m_if.out_count !== 5'd2) begin
         n_fail++;
         $display("FAIL stall_count_last: got %0d expected 2", m_if.out_count);
      end
`endif
      m_if.in_valid = 1'b0;
      m_if.in_vec   = '0;
      @(posedge clk);
      #1;
      n_checks++;
      if (m_if.in_ready !== 1'b1 || m_if.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_done: got in_ready=%b out_valid=%b expected 1/0",
                  m_if.in_ready, m_if.out_valid);
      end
   endtask

   task automatic test_boundaries();
      logic [15:0] single_vec [2] = '{16'h8000, 16'h0001};
      int          single_idx [2] = '{15, 0};
      m_if.out_ready = 1'b1;
      for (int v = 0; v < 2; v++) begin
         m_if.in_vec   = single_vec[v];
         m_if.in_valid = 1'b1;
         @(posedge clk);
         #1;
         m_if.in_valid = 1'b0;
         n_checks++;
         if (m_if.out_valid !== 1'b1 || m_if.out_idx !== 4'(single_idx[v]) ||
             m_if.out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL single_bit%0d: got valid=%b idx=%0d last=%b expected 1 %0d 1",
                     v, m_if.out_valid, m_if.out_idx, m_if.out_last, single_idx[v]);
         end
         @(posedge clk);
         #1;
         n_checks++;
         if (m_if.in_ready !== 1'b1 || m_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done%0d: got in_ready=%b out_valid=%b expected 1/0",
                     v, m_if.in_ready, m_if.out_valid);
         end
      end

      l_if.in_vec    = 16'hFFFF;
      l_if.in_valid  = 1'b1;
      l_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      l_if.in_valid = 1'b0;
      for (int b = 0; b < 16; b++) begin
         n_checks++;
         if (l_if.out_valid !== 1'b1 || l_if.out_idx !== 4'(b) || l_if.out_last !== (b == 15)) begin
            n_fail++;
            $display("FAIL ones_beat%0d: got valid=%b idx=%0d last=%b expected 1 %0d %b",
                     b, l_if.out_valid, l_if.out_idx, l_if.out_last, b, (b == 15));
         end
`ifdef PRIO_SCAN_COUNT_EN
         n_checks++;
         if (l_if.out_count !== 5'd16) begin
            n_fail++;
            $display("FAIL ones_count%0d: got %0d expected 16", b, l_if.out_count);
         end
`endif
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (l_if.in_ready !== 1'b1 || l_if.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ones_done: got in_ready=%b out_valid=%b expected 1/0",
                  l_if.in_ready, l_if.out_valid);
      end
   endtask

   task automatic test_reset_mid_scan();
      m_if.in_vec    = 16'hFFFF;
      m_if.in_valid  = 1'b1;
      m_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      m_if.in_valid = 1'b0;
      m_if.in_vec   = '0;
      for (int b = 0; b < 4; b++) begin
         n_checks++;
         if (m_if.out_idx !== 4'(15 - b)) begin
            n_fail++;
            $display("FAIL rst_scan_beat%0d: got idx=%0d expected %0d", b, m_if.out_idx, 15 - b);
         end
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_async: got out_valid=%b in_ready=%b expected 0/1",
                  m_if.out_valid, m_if.in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      m_if.in_vec   = 16'h0001;
      m_if.in_valid = 1'b1;
      @(posedge clk);
      #1;
      m_if.in_valid = 1'b0;
      m_if.in_vec   = '0;
      n_checks++;
      if (m_if.out_valid !== 1'b1 || m_if.out_idx !== 4'd0 || m_if.out_last !== 1'b1 ||
          m_if.out_none !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_recapture: got valid=%b idx=%0d last=%b none=%b expected 1 0 1 0",
                  m_if.out_valid, m_if.out_idx, m_if.out_last, m_if.out_none);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (m_if.in_ready !== 1'b1 || m_if.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_recapture_done: got in_ready=%b out_valid=%b expected 1/0",
                  m_if.in_ready, m_if.out_valid);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_empty();
      test_stall();
      test_boundaries();
      test_reset_mid_scan();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
